// File: rtl/lod_seq_ctrl.sv
// Multi-cycle leading-zero counter: scans the operand MSB-first one CHUNK-bit slice per cycle
// through a single shared leading-one detector, stopping at the first nonzero slice.
module lod_seq_ctrl #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CHUNK = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(WIDTH):0]   out_lzc,
  output logic                     out_zero,
  output logic                     busy
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CW     = $clog2(WIDTH) + 1;
  localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [KW-1:0] KLast = KW'(NCHUNK - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StScan = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [CW-1:0]    lzc_q, lzc_d;
  logic             zero_q, zero_d;

  logic [CHUNK-1:0] slice;
  logic [CW-1:0]    slice_lzc;
  logic             slice_nz;
  logic [CW-1:0]    slice_base;

  // Slice mux: slice 0 is the most significant CHUNK bits of the operand.
  always_comb begin
    slice = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (k_q == KW'(i)) begin
        slice = op_q[WIDTH-1-i*CHUNK -: CHUNK];
      end
    end
  end

  // Shared detector; the highest set bit is visited last and wins.
  always_comb begin
    slice_lzc = '0;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      if (slice[i]) begin
        slice_lzc = CW'(CHUNK - 1 - i);
      end
    end
  end

  assign slice_nz   = |slice;
  assign slice_base = CW'(k_q) * CW'(CHUNK);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    op_d    = op_q;
    lzc_d   = lzc_q;
    zero_d  = zero_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d    = in_data;
          k_d     = '0;
          state_d = StScan;
        end
      end
      StScan: begin
        if (slice_nz) begin
          lzc_d   = slice_base + slice_lzc;
          zero_d  = 1'b0;
          state_d = StDone;
        end else if (k_q == KLast) begin
          lzc_d   = CW'(WIDTH);
          zero_d  = 1'b1;
          state_d = StDone;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      k_q     <= '0;
      op_q    <= '0;
      lzc_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      op_q    <= op_d;
      lzc_q   <= lzc_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = ~in_ready;
  assign out_lzc   = lzc_q;
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_lod_seq_ctrl.sv
// Directed-vector and random-operand bench for lod_seq_ctrl at WIDTH=64, CHUNK=16.
module tb_lod_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_lzc;
  logic        out_zero;
  logic        busy;

  int n_checks = 0;
  int n_err    = 0;

  lod_seq_ctrl #(
    .WIDTH(64),
    .CHUNK(16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_lzc  (out_lzc),
    .out_zero (out_zero),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    int          stall;
    int          exp_lzc;
    bit          exp_zero;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_lzc(input logic [63:0] d);
    for (int i = 63; i >= 0; i--) begin
      if (d[i]) return 63 - i;
    end
    return 64;
  endfunction

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic send(input logic [63:0] d, input int stall, input int exp_lzc,
                      input bit exp_zero, input int exp_lat);
    int lat;
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
    chk("busy_scan", busy, 1);
    chk("in_ready_scan", in_ready, 0);
    wait_result(lat);
    chk("latency", lat, exp_lat);
    chk("out_lzc", out_lzc, exp_lzc);
    chk("out_zero", out_zero, exp_zero);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      chk("stall_valid", out_valid, 1);
      chk("stall_lzc", out_lzc, exp_lzc);
      chk("stall_in_ready", in_ready, 0);
    end
    handshake();
    chk("in_ready_after_hs", in_ready, 1);
    chk("out_valid_after_hs", out_valid, 0);
    chk("busy_after_hs", busy, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    vecs[0] = '{64'h8000_0000_0000_0000, 0, 0,  1'b0, 1};
    vecs[1] = '{64'h0000_0000_0001_0000, 0, 47, 1'b0, 3};
    vecs[2] = '{64'h0000_0000_0000_0000, 0, 64, 1'b1, 4};
    vecs[3] = '{64'h0000_0001_0000_0000, 2, 31, 1'b0, 2};
    vecs[4] = '{64'h00FF_0000_0000_0000, 0, 8,  1'b0, 1};
    vecs[5] = '{64'h0000_0000_0000_0001, 1, 63, 1'b0, 4};
    vecs[6] = '{64'h4000_0000_0000_0000, 0, 1,  1'b0, 1};
    vecs[7] = '{64'h0000_8000_0000_0000, 0, 16, 1'b0, 2};
    vecs[8] = '{64'h0000_0000_8000_0000, 3, 32, 1'b0, 3};
    vecs[9] = '{64'h0001_FFFF_FFFF_FFFF, 0, 15, 1'b0, 1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_lzc", out_lzc, 0);
    chk("rst_out_zero", out_zero, 0);
    chk("rst_busy", busy, 0);

    foreach (vecs[i]) begin
      send(vecs[i].data, vecs[i].stall, vecs[i].exp_lzc, vecs[i].exp_zero, vecs[i].exp_lat);
    end

    // Backpressure with a second operand held on in_valid throughout.
    in_valid = 1'b1;
    in_data  = 64'h0000_0001_0000_0000;
    @(posedge clk);
    #1;
    in_data = 64'h00FF_0000_0000_0000;
    wait_result(lat);
    chk("bp_latency", lat, 2);
    chk("bp_lzc", out_lzc, 31);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_stall_lzc", out_lzc, 31);
      chk("bp_stall_valid", out_valid, 1);
    end
    handshake();
    chk("bp_in_ready_after", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_second_busy", busy, 1);
    wait_result(lat);
    chk("bp_second_latency", lat, 1);
    chk("bp_second_lzc", out_lzc, 8);
    handshake();

    // Reset during the second SCAN cycle drops the operation.
    in_valid = 1'b1;
    in_data  = 64'h0000_0000_0000_0001;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_lzc", out_lzc, 0);
    chk("mid_rst_busy", busy, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("mid_rst_no_result", out_valid, 0);
    end
    send(64'h4000_0000_0000_0000, 0, 1, 1'b0, 1);

    // Random operands biased toward sparse and all-zero words.
    for (int n = 0; n < 5000; n++) begin
      logic [63:0] d;
      int          m;
      int          lz;
      m = $urandom_range(0, 3);
      case (m)
        0:       d = '0;
        1:       d = 64'd1 << $urandom_range(0, 63);
        2:       d = {$urandom, $urandom} >> $urandom_range(0, 63);
        default: d = {$urandom, $urandom};
      endcase
      lz = model_lzc(d);
      send(d, $urandom_range(0, 2), lz, (d == 64'd0), (lz == 64) ? 4 : (lz / 16) + 1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
